// File: rtl/el2_lsu_clken_sched.sv
// Clock-enable scheduler for the LSU gated clock domains, with a quiesce handshake.
// Optional gated-cycle counter is built only when LSU_CLKEN_PERF_EN is defined.

module el2_lsu_clken_dom #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              act,
  input  logic              wake_req,
  input  logic              wake_ok,
  input  logic              clk_override,
  input  logic [HOLD_W-1:0] hold_val,
  output logic              clken,
  output logic              dom_on,
  output logic              wake_ack
);
  typedef enum logic [1:0] {D_OFF, D_ON, D_HOLD} dst_t;

  dst_t              st, st_nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      st  <= D_OFF;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      D_OFF:
        if (act || (wake_req && wake_ok)) st_nxt = D_ON;
      D_ON:
        if (!(act || wake_req)) begin
          // hold_val is sampled here only; later reloads don't disturb a running countdown
          if (hold_val == '0) st_nxt = D_OFF;
          else begin
            st_nxt  = D_HOLD;
            cnt_nxt = hold_val;
          end
        end
      D_HOLD:
        if (act || wake_req) st_nxt = D_ON;
        else if (cnt == '0)  st_nxt = D_OFF;
        else                 cnt_nxt = cnt - HOLD_W'(1);
      default: st_nxt = D_OFF;
    endcase
  end

  assign dom_on   = (st != D_OFF);
  assign clken    = act | dom_on | clk_override;
  assign wake_ack = wake_req & dom_on;
endmodule

module el2_lsu_clken_sched #(
  parameter int              NUM_DOM  = 4,
  parameter int              HOLD_W   = 4,
  parameter logic [HOLD_W-1:0] DEF_HOLD = HOLD_W'(2)
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               clk_override,
  input  logic [HOLD_W-1:0]  hold_cfg,
  input  logic               hold_cfg_we,
  input  logic [NUM_DOM-1:0] act,
  input  logic [NUM_DOM-1:0] wake_req,
  output logic [NUM_DOM-1:0] wake_ack,
  output logic [NUM_DOM-1:0] clken,
  output logic [NUM_DOM-1:0] dom_on,
  input  logic               quiesce_req,
  output logic               quiesce_ack,
  output logic [31:0]        gated_cycles
);
  typedef enum logic [1:0] {T_RUN, T_DRAIN, T_QUIET} tst_t;

  tst_t              top, top_nxt;
  logic [HOLD_W-1:0] hold_reg;
  logic              wake_ok;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      top      <= T_RUN;
      hold_reg <= DEF_HOLD;
    end else begin
      top <= top_nxt;
      if (hold_cfg_we) hold_reg <= hold_cfg;
    end
  end

  always_comb begin
    top_nxt = top;
    case (top)
      T_RUN:
        if (quiesce_req) top_nxt = T_DRAIN;
      T_DRAIN:
        if (!quiesce_req)                 top_nxt = T_RUN;
        else if (~|dom_on && ~|act)       top_nxt = T_QUIET;
      T_QUIET:
        if (!quiesce_req)                 top_nxt = T_RUN;
        else if (|act)                    top_nxt = T_DRAIN;
      default: top_nxt = T_RUN;
    endcase
  end

  // New wakes are refused once draining; domains already up keep acking
  assign wake_ok     = (top != T_DRAIN) && (top != T_QUIET);
  assign quiesce_ack = (top == T_QUIET);

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    el2_lsu_clken_dom #(.HOLD_W(HOLD_W)) u_dom (
      .clk          (clk),
      .rst_l        (rst_l),
      .act          (act[i]),
      .wake_req     (wake_req[i]),
      .wake_ok      (wake_ok),
      .clk_override (clk_override),
      .hold_val     (hold_reg),
      .clken        (clken[i]),
      .dom_on       (dom_on[i]),
      .wake_ack     (wake_ack[i])
    );
  end

`ifdef LSU_CLKEN_PERF_EN
  logic [31:0] gcnt;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                                gcnt <= '0;
    else if (~|clken && gcnt != 32'hFFFF_FFFF) gcnt <= gcnt + 32'd1;
  end
  assign gated_cycles = gcnt;
`else
  assign gated_cycles = '0;
`endif
endmodule

// File: tb/tb_el2_lsu_clken_sched.sv
// Directed bench for el2_lsu_clken_sched: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.

module tb_el2_lsu_clken_sched;
  localparam int NUM_DOM = 4;
  localparam int HOLD_W  = 4;

  logic               clk = 1'b0;
  logic               rst_l;
  logic               clk_override;
  logic [HOLD_W-1:0]  hold_cfg;
  logic               hold_cfg_we;
  logic [NUM_DOM-1:0] act;
  logic [NUM_DOM-1:0] wake_req;
  logic [NUM_DOM-1:0] wake_ack;
  logic [NUM_DOM-1:0] clken;
  logic [NUM_DOM-1:0] dom_on;
  logic               quiesce_req;
  logic               quiesce_ack;
  logic [31:0]        gated_cycles;

  el2_lsu_clken_sched #(.NUM_DOM(NUM_DOM), .HOLD_W(HOLD_W), .DEF_HOLD(4'd2)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .clk_override (clk_override),
    .hold_cfg     (hold_cfg),
    .hold_cfg_we  (hold_cfg_we),
    .act          (act),
    .wake_req     (wake_req),
    .wake_ack     (wake_ack),
    .clken        (clken),
    .dom_on       (dom_on),
    .quiesce_req  (quiesce_req),
    .quiesce_ack  (quiesce_ack),
    .gated_cycles (gated_cycles)
  );

  always #5 clk = ~clk;

  localparam int S_CLKEN = 0, S_DOMON = 1, S_WACK = 2, S_QACK = 3, S_GATED = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_CLKEN: return 32'(clken);
      S_DOMON: return 32'(dom_on);
      S_WACK:  return 32'(wake_ack);
      S_QACK:  return 32'(quiesce_ack);
      default: return gated_cycles;
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the current cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      n_tests++;
      a = observe(e.sel);
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
      end else if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", e.name, cyc, a, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic ex(int sel, logic [31:0] v, string n);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] gexp(int n);
`ifdef LSU_CLKEN_PERF_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0; clk_override = 1'b0; hold_cfg = '0; hold_cfg_we = 1'b0;
    act = 4'b0101; wake_req = '0; quiesce_req = 1'b0;

    // Reset: clken is combinational pass-through of act / override
    step();
    ex(S_CLKEN, 32'h5, "rst_clken_act"); ex(S_DOMON, 0, "rst_dom_on");
    ex(S_WACK, 0, "rst_wake_ack"); ex(S_QACK, 0, "rst_qack"); ex(S_GATED, 0, "rst_gated");
    step();
    act = '0; clk_override = 1'b1;
    ex(S_CLKEN, 32'hF, "rst_clken_ovr"); ex(S_DOMON, 0, "rst_dom_on_ovr");
    step();
    clk_override = 1'b0; rst_l = 1'b1;
    ex(S_CLKEN, 0, "idle_clken");

    // 10 idle cycles
    steps(10);
    ex(S_GATED, gexp(10), "gated_10_idle");

    // hold 3, act[0] pulse
    hold_cfg = 4'd3; hold_cfg_we = 1'b1;
    step();
    hold_cfg_we = 1'b0; act = 4'b0001;
    ex(S_CLKEN, 32'h1, "a0_T_clken"); ex(S_DOMON, 0, "a0_T_dom_on"); ex(S_GATED, gexp(11), "gated_11");
    step();
    act = '0;
    ex(S_CLKEN, 32'h1, "a0_T1_clken"); ex(S_DOMON, 32'h1, "a0_T1_dom_on");
    ex(S_GATED, gexp(11), "gated_frozen_T1");
    steps(4);
    ex(S_CLKEN, 32'h1, "a0_T5_clken"); ex(S_DOMON, 32'h1, "a0_T5_dom_on");
    step();
    ex(S_CLKEN, 0, "a0_T6_clken"); ex(S_DOMON, 0, "a0_T6_dom_on");
    ex(S_GATED, gexp(11), "gated_frozen_T6");
    step();
    // wake_req[1] held
    wake_req = 4'b0010;
    ex(S_GATED, gexp(12), "gated_12");
    ex(S_WACK, 0, "w1_T_ack"); ex(S_CLKEN, 0, "w1_T_clken");
    step();
    ex(S_WACK, 32'h2, "w1_T1_ack"); ex(S_CLKEN, 32'h2, "w1_T1_clken"); ex(S_DOMON, 32'h2, "w1_T1_dom_on");
    step();
    ex(S_WACK, 32'h2, "w1_T2_ack");
    step();
    wake_req = '0;
    ex(S_WACK, 0, "w1_T3_ack"); ex(S_CLKEN, 32'h2, "w1_T3_clken");
    steps(4);
    ex(S_DOMON, 32'h2, "w1_hold_last");
    step();
    ex(S_DOMON, 0, "w1_off"); ex(S_CLKEN, 0, "w1_off_clken");

    // hold 0: ON then straight OFF
    hold_cfg = 4'd0; hold_cfg_we = 1'b1;
    step();
    hold_cfg_we = 1'b0; act = 4'b0100;
    ex(S_CLKEN, 32'h4, "h0_T_clken"); ex(S_DOMON, 0, "h0_T_dom_on");
    step();
    act = '0;
    ex(S_CLKEN, 32'h4, "h0_T1_clken"); ex(S_DOMON, 32'h4, "h0_T1_dom_on");
    step();
    ex(S_CLKEN, 0, "h0_T2_clken"); ex(S_DOMON, 0, "h0_T2_dom_on");

    // Quiesce with domain 0 in HOLD
    hold_cfg = 4'd3; hold_cfg_we = 1'b1;
    step();
    hold_cfg_we = 1'b0; act = 4'b0001;
    step();
    act = '0;
    steps(2);                        // HOLD, cnt = 2
    quiesce_req = 1'b1;
    ex(S_QACK, 0, "q_req_qack");
    step();                          // DRAIN, cnt = 1
    wake_req = 4'b1000;
    ex(S_WACK, 0, "q_drain_wack3");
    step();                          // cnt = 0
    ex(S_WACK, 0, "q_drain_wack3_b"); ex(S_DOMON, 32'h1, "q_hold_cnt0");
    step();                          // dom0 OFF
    ex(S_DOMON, 0, "q_dom0_off"); ex(S_QACK, 0, "q_qack_pending");
    step();
    ex(S_QACK, 1, "q_quiet"); ex(S_WACK, 0, "q_quiet_wack3"); ex(S_DOMON, 0, "q_quiet_dom_on");
    step();
    wake_req = '0; act = 4'b1000;
    ex(S_QACK, 1, "q_act_same_cycle"); ex(S_CLKEN, 32'h8, "q_act_clken");
    step();
    act = '0;
    ex(S_QACK, 0, "q_ack_drop"); ex(S_DOMON, 32'h8, "q_dom3_on");
    steps(5);
    ex(S_DOMON, 0, "q_dom3_off"); ex(S_QACK, 0, "q_drain_again");
    step();
    ex(S_QACK, 1, "q_quiet_again");
    step();
    quiesce_req = 1'b0;
    step();
    ex(S_QACK, 0, "q_run");

    // Override: forces clken only
    clk_override = 1'b1; quiesce_req = 1'b1;
    ex(S_CLKEN, 32'hF, "ovr_clken"); ex(S_DOMON, 0, "ovr_dom_on");
    step();
    ex(S_QACK, 0, "ovr_drain");
    step();
    ex(S_QACK, 1, "ovr_quiet"); ex(S_CLKEN, 32'hF, "ovr_quiet_clken");
    step();
    clk_override = 1'b0; quiesce_req = 1'b0;
    ex(S_CLKEN, 0, "ovr_off_clken"); ex(S_QACK, 1, "ovr_quiet_hold");
    step();
    ex(S_QACK, 0, "ovr_run");

    // quiesce_req together with wake in OFF: wake accepted
    quiesce_req = 1'b1; wake_req = 4'b0001;
    ex(S_WACK, 0, "qw_T_ack");
    step();
    ex(S_WACK, 32'h1, "qw_T1_ack"); ex(S_DOMON, 32'h1, "qw_T1_dom_on");
    step();
    quiesce_req = 1'b0; wake_req = '0;
    steps(3);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
    end
    done = 1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
